vga_scanout_ctrl: RTL and testbench

//  Parametrised VGA scan-out controller: owns h/v timing counters, generates Hsync/Vsync, and

---
 rtl/vga_scanout_ctrl_if.sv | 27 ++
 rtl/vga_scanout_ctrl.sv | 110 +++++++++++
 tb/tb_vga_scanout_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_ctrl_if.sv
// vga_scanout_ctrl_if: pixel-side bundle between the scan-out controller, its frame RAM and the VGA pins
// Ports (master = RAM/pin side, slave = controller):
//   pix_en, ColorIn, page_swap_req            -> controller
//   Address, Hsync, Vsync, ColorOut,
//   page_sel, frame_start                     <- controller
interface vga_scanout_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int COLOR_W = 8
);
  logic pix_en;
  logic [COLOR_W-1:0] ColorIn;
  logic page_swap_req;
  logic [ADDR_W-1:0] Address;
  logic Hsync;
  logic Vsync;
  logic [COLOR_W-1:0] ColorOut;
  logic page_sel;
  logic frame_start;
  modport master (
    output pix_en, ColorIn, page_swap_req,
    input Address, Hsync, Vsync, ColorOut, page_sel, frame_start
  );
  modport slave (
    input pix_en, ColorIn, page_swap_req,
    output Address, Hsync, Vsync, ColorOut, page_sel, frame_start
  );
endinterface

// File: rtl/vga_scanout_ctrl.sv
// vga_scanout_ctrl: VGA timing counters, sync generation and scaled two-page framebuffer addressing
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    vga_scanout_ctrl_if.slave (pix_en, ColorIn, page_swap_req in;
//          Address, Hsync, Vsync, ColorOut, page_sel, frame_start out)
// Optional feature: define VGA_BORDER_EN to paint the outermost visible ring with BORDER_COLOR.
module vga_scanout_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int COL_W = 8,
  parameter int ROW_W = 7,
  parameter int ADDR_W = 16,
  parameter int COLOR_W = 8,
  parameter int PAGE0_BASE = 1000,
  parameter int PAGE1_BASE = 33768,
  parameter logic [COLOR_W-1:0] BLANK_COLOR = '0
`ifdef VGA_BORDER_EN
  , parameter logic [COLOR_W-1:0] BORDER_COLOR = 8'b00011100
`endif
) (
  input logic clk,
  input logic reset,
  vga_scanout_ctrl_if.slave bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // counters must be wide enough both for the timing range and for the scaled address slices
  localparam int HW = ($clog2(H_TOTAL) > SCALE_SHIFT + COL_W) ? $clog2(H_TOTAL) : SCALE_SHIFT + COL_W;
  localparam int VW = ($clog2(V_TOTAL) > SCALE_SHIFT + ROW_W) ? $clog2(V_TOTAL) : SCALE_SHIFT + ROW_W;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_ON = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_OFF = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VISIBLE - 1);
  localparam logic [VW-1:0] VS_ON = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_OFF = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [0:0] state;
  logic h_end, v_end, flip;
  logic vis1, hs1, vs1;
  logic [COLOR_W-1:0] pix;
  assign h_end = h == H_LAST;
  assign v_end = v == V_LAST;
  // flip on the tick that leaves the last visible line, so the new page starts cleanly after blanking
  assign flip = bus.pix_en && h_end && v == V_VIS_LAST;
  assign bus.Address = (bus.page_sel ? ADDR_W'(PAGE1_BASE) : ADDR_W'(PAGE0_BASE))
                     + ADDR_W'({v[SCALE_SHIFT+:ROW_W], h[SCALE_SHIFT+:COL_W]});
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (bus.pix_en) begin
      h <= h_end ? '0 : h + HW'(1);
      if (h_end) v <= v_end ? '0 : v + VW'(1);
    end
  // a request arriving on the flip tick itself toggles at once; repeats while pending collapse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.page_sel <= 1'b0;
    end else if (flip && (state == PENDING || bus.page_swap_req)) begin
      state <= IDLE;
      bus.page_sel <= ~bus.page_sel;
    end else if (bus.page_swap_req) begin
      state <= PENDING;
    end
`ifdef VGA_BORDER_EN
  logic edge1;
  always_ff @(posedge clk or posedge reset)
    if (reset) edge1 <= 1'b0;
    else if (bus.pix_en) edge1 <= h == '0 || h == H_VIS - HW'(1) || v == '0 || v == V_VIS_LAST;
  assign pix = edge1 ? BORDER_COLOR : bus.ColorIn;
`else
  assign pix = bus.ColorIn;
`endif
  // stage 1 waits out the RAM read; stage 2 pairs the delayed flags with the returned colour
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vis1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      bus.Hsync <= ~SYNC_ACTIVE;
      bus.Vsync <= ~SYNC_ACTIVE;
      bus.ColorOut <= BLANK_COLOR;
    end else if (bus.pix_en) begin
      vis1 <= h < H_VIS && v < V_VIS;
      hs1 <= h >= HS_ON && h < HS_OFF;
      vs1 <= v >= VS_ON && v < VS_OFF;
      bus.Hsync <= hs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      bus.Vsync <= vs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      bus.ColorOut <= vis1 ? pix : BLANK_COLOR;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.frame_start <= 1'b0;
    else bus.frame_start <= bus.pix_en && h_end && v_end;
endmodule

// File: tb/tb_vga_scanout_ctrl.sv
// tb_vga_scanout_ctrl: randomized self-checking bench for vga_scanout_ctrl on a reduced timing grid
module tb_vga_scanout_ctrl;
  localparam int HV = 32, HF = 4, HSY = 8, HB = 4;
  localparam int VV = 16, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int FLIP = (VV - 1) * HT + HT - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int p = 0;
  int p1 = -1;
  logic pg = 1'b0;
  logic pend = 1'b0;
  logic exp_hs = 1'b0;
  logic exp_vs = 1'b0;
  logic exp_fs = 1'b0;
  logic [7:0] exp_col = 8'h00;
  vga_scanout_ctrl_if #(.ADDR_W(16), .COLOR_W(8)) bus();
  vga_scanout_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic hs_of(int q);
    return (q % HT) >= HV + HF && (q % HT) < HV + HF + HSY;
  endfunction
  function automatic logic vs_of(int q);
    return (q / HT) >= VV + VF && (q / HT) < VV + VF + VSY;
  endfunction
  function automatic logic vis_of(int q);
    return (q % HT) < HV && (q / HT) < VV;
  endfunction
`ifdef VGA_BORDER_EN
  function automatic logic brd_of(int q);
    return (q % HT) == 0 || (q % HT) == HV - 1 || (q / HT) == 0 || (q / HT) == VV - 1;
  endfunction
`endif
  function automatic logic [15:0] addr_of(int q, logic pgx);
    int a;
    a = (pgx ? 33768 : 1000) + ((((q / HT) >> 2) & 127) * 256) + (((q % HT) >> 2) & 255);
    return a[15:0];
  endfunction
  task automatic model_reset;
    p = 0; p1 = -1; pg = 1'b0; pend = 1'b0;
    exp_hs = 1'b0; exp_vs = 1'b0; exp_fs = 1'b0; exp_col = 8'h00;
  endtask
  task automatic step(input logic en, input logic req, input logic [7:0] cin);
    bus.pix_en = en;
    bus.page_swap_req = req;
    bus.ColorIn = cin;
    @(posedge clk);
    exp_fs = 1'b0;
    if (en && p == FLIP && (pend || req)) begin
      pg = ~pg;
      pend = 1'b0;
    end else if (req) pend = 1'b1;
    if (en) begin
      exp_hs = p1 >= 0 && hs_of(p1);
      exp_vs = p1 >= 0 && vs_of(p1);
`ifdef VGA_BORDER_EN
      exp_col = (p1 >= 0 && vis_of(p1)) ? (brd_of(p1) ? 8'h1C : cin) : 8'h00;
`else
      exp_col = (p1 >= 0 && vis_of(p1)) ? cin : 8'h00;
`endif
      p1 = p;
      p = (p + 1) % FT;
      exp_fs = p == 0;
    end
    #1;
    bus.page_swap_req = 1'b0;
  endtask
  task automatic do_reset;
    bus.pix_en = 1'b0;
    bus.page_swap_req = 1'b0;
    bus.ColorIn = 8'h00;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask
  task automatic test_reset;
    do_reset();
    step(1'b1, 1'b1, 8'h11);
    repeat (903) step(1'b1, 1'b0, 8'($urandom));
    tests++;
    if (bus.page_sel !== pg || bus.Hsync !== ~exp_hs || bus.Vsync !== ~exp_vs) begin
      fails++;
      $display("FAIL pre_reset page=%b hs=%b vs=%b want page=%b hs=%b vs=%b", bus.page_sel, bus.Hsync, bus.Vsync, pg, ~exp_hs, ~exp_vs);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (bus.Hsync !== 1'b1 || bus.Vsync !== 1'b1 || bus.ColorOut !== 8'h00 || bus.frame_start !== 1'b0 || bus.page_sel !== 1'b0) begin
      fails++;
      $display("FAIL async_reset hs=%b vs=%b col=%h fs=%b page=%b want 1 1 00 0 0", bus.Hsync, bus.Vsync, bus.ColorOut, bus.frame_start, bus.page_sel);
    end
    tests++;
    if (bus.Address !== 16'd1000) begin
      fails++;
      $display("FAIL reset_addr got %0d want 1000", bus.Address);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 8'h00);
    tests++;
    if (bus.Address !== addr_of(p, pg) || bus.Hsync !== 1'b1) begin
      fails++;
      $display("FAIL post_reset addr=%0d hs=%b want %0d 1", bus.Address, bus.Hsync, addr_of(p, pg));
    end
  endtask
  task automatic test_address;
    do_reset();
    repeat (8 * HT + 4) step(1'b1, 1'b0, 8'($urandom));
    tests++;
    if (bus.Address !== 16'd1513) begin
      fails++;
      $display("FAIL addr_4_8 got %0d want 1513", bus.Address);
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h5A);
    tests++;
    if (bus.ColorOut !== 8'h5A) begin
      fails++;
      $display("FAIL color_5a got %h want 5a", bus.ColorOut);
    end
  endtask
  task automatic test_sync_widths;
    int hs_low, vs_low, fs_cnt, run, last_fall, falls;
    logic prev;
    hs_low = 0; vs_low = 0; fs_cnt = 0; run = 0; last_fall = -1; falls = 0; prev = 1'b1;
    do_reset();
    repeat (FT) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < FT; i++) begin
      step(1'b1, 1'b0, 8'($urandom));
      if (bus.Hsync === 1'b0) begin hs_low++; run++; end
      if (bus.Vsync === 1'b0) vs_low++;
      if (bus.frame_start === 1'b1) fs_cnt++;
      if (p % HT == HV + HF + 1 || p % HT == HV + HF + 2) begin
        tests++;
        if (bus.Hsync !== (p % HT == HV + HF + 1)) begin
          fails++;
          $display("FAIL hs_onset h=%0d got %b want %b", p % HT, bus.Hsync, p % HT == HV + HF + 1);
        end
      end
      if (prev === 1'b1 && bus.Hsync === 1'b0) begin
        if (last_fall >= 0) begin
          tests++;
          if (i - last_fall != HT) begin
            fails++;
            $display("FAIL hs_period got %0d want %0d", i - last_fall, HT);
          end
        end
        last_fall = i;
        falls++;
      end
      if (prev === 1'b0 && bus.Hsync === 1'b1 && falls > 0) begin
        tests++;
        if (run != HSY) begin
          fails++;
          $display("FAIL hs_width got %0d want %0d", run, HSY);
        end
      end
      if (bus.Hsync === 1'b1) run = 0;
      prev = bus.Hsync;
    end
    tests++;
    if (hs_low != VT * HSY || vs_low != VSY * HT || fs_cnt != 1) begin
      fails++;
      $display("FAIL frame_counts hs_low=%0d vs_low=%0d fs=%0d want %0d %0d 1", hs_low, vs_low, fs_cnt, VT * HSY, VSY * HT);
    end
  endtask
  task automatic to_flip;
    for (int i = 0; i < FT && p != FLIP; i++) step(1'b1, 1'b0, 8'h00);
  endtask
  task automatic test_page_swap;
    do_reset();
    repeat (5 * HT) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    repeat (10 * HT) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    to_flip();
    tests++;
    if (bus.page_sel !== 1'b0) begin
      fails++;
      $display("FAIL swap_before got %b want 0", bus.page_sel);
    end
    step(1'b1, 1'b0, 8'h00);
    tests++;
    if (bus.page_sel !== 1'b1) begin
      fails++;
      $display("FAIL swap_after got %b want 1", bus.page_sel);
    end
    for (int i = 0; i < FT && p != 0; i++) step(1'b1, 1'b0, 8'h00);
    tests++;
    if (bus.Address !== 16'd33768) begin
      fails++;
      $display("FAIL page1_origin got %0d want 33768", bus.Address);
    end
    to_flip();
    step(1'b1, 1'b0, 8'h00);
    tests++;
    if (bus.page_sel !== 1'b1) begin
      fails++;
      $display("FAIL single_flip got %b want 1", bus.page_sel);
    end
    to_flip();
    step(1'b1, 1'b1, 8'h00);
    tests++;
    if (bus.page_sel !== 1'b0) begin
      fails++;
      $display("FAIL same_clk_flip got %b want 0", bus.page_sel);
    end
    step(1'b0, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    to_flip();
    step(1'b1, 1'b0, 8'h00);
    tests++;
    if (bus.page_sel !== 1'b1) begin
      fails++;
      $display("FAIL idle_req_flip got %b want 1", bus.page_sel);
    end
  endtask
  task automatic test_half_rate;
    int fs_cnt, run, falls;
    logic prev, prev_fs;
    fs_cnt = 0; run = 0; falls = 0; prev = 1'b1; prev_fs = 1'b0;
    do_reset();
    for (int i = 0; i < 4 * FT; i++) begin
      step(i % 2 == 0, 1'b0, 8'($urandom));
      if (i % 2 == 1) begin
        tests++;
        if (bus.ColorOut !== exp_col || bus.Hsync !== ~exp_hs || bus.Vsync !== ~exp_vs || (vis_of(p) && bus.Address !== addr_of(p, pg))) begin
          fails++;
          $display("FAIL idle_hold col=%h hs=%b vs=%b addr=%0d want %h %b %b %0d", bus.ColorOut, bus.Hsync, bus.Vsync, bus.Address, exp_col, ~exp_hs, ~exp_vs, addr_of(p, pg));
        end
      end
      if (bus.frame_start === 1'b1) fs_cnt++;
      tests++;
      if (prev_fs === 1'b1 && bus.frame_start !== 1'b0) begin
        fails++;
        $display("FAIL fs_width got %b want 0", bus.frame_start);
      end
      prev_fs = bus.frame_start;
      if (bus.Hsync === 1'b0) run++;
      if (prev === 1'b1 && bus.Hsync === 1'b0) falls++;
      if (prev === 1'b0 && bus.Hsync === 1'b1 && falls > 0) begin
        tests++;
        if (run != 2 * HSY) begin
          fails++;
          $display("FAIL hs_width_half got %0d want %0d", run, 2 * HSY);
        end
      end
      if (bus.Hsync === 1'b1) run = 0;
      prev = bus.Hsync;
    end
    tests++;
    if (fs_cnt != 2) begin
      fails++;
      $display("FAIL fs_count_half got %0d want 2", fs_cnt);
    end
  endtask
  task automatic test_random;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 400) == 0, 8'($urandom));
      tests++;
      if (bus.Hsync !== ~exp_hs || bus.Vsync !== ~exp_vs || bus.ColorOut !== exp_col || bus.page_sel !== pg || bus.frame_start !== exp_fs) begin
        fails++;
        $display("FAIL rand_out i=%0d hs=%b vs=%b col=%h page=%b fs=%b want %b %b %h %b %b", i, bus.Hsync, bus.Vsync, bus.ColorOut, bus.page_sel, bus.frame_start, ~exp_hs, ~exp_vs, exp_col, pg, exp_fs);
      end
      if (vis_of(p)) begin
        tests++;
        if (bus.Address !== addr_of(p, pg)) begin
          fails++;
          $display("FAIL rand_addr i=%0d got %0d want %0d", i, bus.Address, addr_of(p, pg));
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_address();
    test_sync_widths();
    test_page_swap();
    test_half_rate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
